// File: rtl/fixed_pkg.sv
// Shared fixed-point constants, widths and FSM encoding for the power/root engines.
package fixed_pkg;
  localparam int DATA_W    = 20;
  localparam int FRAC_BITS = 10;
  localparam int EXP_W     = 3;

  localparam logic [DATA_W-1:0] FXP_ONE = 20'h00400;
  localparam logic [DATA_W-1:0] FXP_SAT = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational unsigned fixed-point multiply with realignment and saturation.
module fxp_mul_sat
  import fixed_pkg::*;
#(
  parameter int DATA_W    = fixed_pkg::DATA_W,
  parameter int FRAC_BITS = fixed_pkg::FRAC_BITS
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);
  logic [2*DATA_W-1:0] w_prod;
  logic                w_unused_lsb;

  assign w_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Any bit above the realigned result window means the value does not fit.
  assign ovf          = |w_prod[2*DATA_W-1:DATA_W+FRAC_BITS];
  assign y            = ovf ? {DATA_W{1'b1}} : w_prod[DATA_W+FRAC_BITS-1:FRAC_BITS];
  assign w_unused_lsb = ^w_prod[FRAC_BITS-1:0];
endmodule

// File: rtl/fixed_power.sv
// Raises an unsigned Q10.10 base to a small integer exponent, one saturating multiply per cycle.
module fixed_power
  import fixed_pkg::*;
#(
  parameter int DATA_W    = fixed_pkg::DATA_W,
  parameter int FRAC_BITS = fixed_pkg::FRAC_BITS,
  parameter int EXP_W     = fixed_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [EXP_W-1:0]  in_data_2,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf
);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(FXP_ONE);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_x;
  logic [EXP_W-1:0]  r_n;
  logic [DATA_W-1:0] r_acc;
  logic [EXP_W-1:0]  r_cnt;
  logic              r_sat;
  logic              r_busy;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_ovf;
  logic              w_accept;
  logic              w_last;
  logic [DATA_W-1:0] w_prod;
  logic              w_ovf;

  fxp_mul_sat #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .a   (r_acc),
    .b   (r_x),
    .y   (w_prod),
    .ovf (w_ovf)
  );

  // The out_valid cycle is already IDLE but still closes the previous op, so starts wait one more cycle.
  assign w_accept = (r_state == IDLE) && in_valid && !r_out_valid;
  assign w_last   = (r_cnt == r_n - EXP_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (in_data_2 != '0) ? MUL : OUT;
      MUL:  if (w_last) w_next = OUT;
      OUT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_x         <= '0;
      r_n         <= '0;
      r_acc       <= ONE;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != IDLE);
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= in_data_1;
            r_n   <= in_data_2;
            r_acc <= ONE;
            r_sat <= 1'b0;
            r_cnt <= '0;
          end
        end
        MUL: begin
          // Once saturated the accumulator is pinned, even if a later product would fit.
          r_acc <= r_sat ? {DATA_W{1'b1}} : w_prod;
          r_sat <= r_sat | w_ovf;
          r_cnt <= r_cnt + EXP_W'(1);
        end
        OUT: begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_acc;
          r_out_ovf   <= r_sat;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_fixed_power.sv
// Scoreboard bench for fixed_power: expected results queued at issue, compared on out_valid.
module tb_fixed_power;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] in_data_1 = '0;
  logic [2:0]  in_data_2 = '0;
  logic        busy;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ovf;

  typedef struct {
    logic [19:0] d;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  fixed_power dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called on a negedge; in_valid is sampled by the following posedge.
  task automatic issue(input logic [19:0] x, input logic [2:0] n,
                       input logic [19:0] d, input logic ovf);
    exp_t e;
    e.d   = d;
    e.ovf = ovf;
    e.cyc = cyc + int'(n) + 2;
    q.push_back(e);
    in_valid  = 1'b1;
    in_data_1 = x;
    in_data_2 = n;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
    check("idle_zero", {busy, out_valid, out_ovf, out_data}, 32'd0);
  endtask

  logic [19:0] tx [11] = '{20'h00800, 20'h00600, 20'h00200, 20'h00001, 20'h12345, 20'h00000,
                           20'hFFC00, 20'h08000, 20'h07C00, 20'h12345, 20'h00000};
  logic [2:0]  tn [11] = '{3'd3, 3'd2, 3'd7, 3'd2, 3'd0, 3'd5, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0};
  logic [19:0] td [11] = '{20'h02000, 20'h00900, 20'h00008, 20'h00000, 20'h00400, 20'h00000,
                           20'hFFFFF, 20'hFFFFF, 20'hF0400, 20'h12345, 20'h00400};
  logic        to [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, out_valid, out_ovf, out_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, out_valid, out_ovf, out_data}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      issue(tx[i], tn[i], td[i], to[i]);
      drain();
    end

    // Overlap: re-pulses during MUL and in the out_valid cycle are ignored.
    issue(20'h00800, 3'd3, 20'h02000, 1'b0);
    in_valid = 1'b1; in_data_1 = 20'hFFC00; in_data_2 = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("overlap_saw_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data_1 = 20'hFFC00; in_data_2 = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("ovcycle_not_busy", 32'(busy), 32'd0);
    issue(20'h00600, 3'd2, 20'h00900, 1'b0);
    drain();

    // Reset during the third multiply of n=5: nothing may come out.
    in_valid = 1'b1; in_data_1 = 20'h00800; in_data_2 = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {busy, out_valid, out_ovf, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_result", {busy, out_valid, out_ovf, out_data}, 32'd0);
    issue(20'h00C00, 3'd2, 20'h02400, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
